// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid register: occupancy encoding
// doubles as the FSM state, so the state is always visible on the port.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t OCC_EMPTY = 2'd0;
    localparam state_t OCC_BUSY  = 2'd1;
    localparam state_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer, flush and back-pressure.
// All outputs are decoded from flops; in_ready never depends on out_ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high; a producer holding valid must keep its data stable until
    // ready, and valid may not be withdrawn before the transfer completes.

    state_t            state;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              drain;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;

    // state[1] is the skid flag; 2'd3 is the unreachable skid-without-main case.
    assign main_valid = (state == OCC_BUSY) || (state == OCC_FULL);
    assign skid_valid = state[1];

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = state;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else if (flush) begin
            state <= OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (accept) state <= OCC_BUSY;
                OCC_BUSY: begin
                    if (accept && !drain)      state <= OCC_FULL;
                    else if (!accept && drain) state <= OCC_EMPTY;
                end
                OCC_FULL:  if (drain) state <= OCC_BUSY;
                default:   state <= OCC_EMPTY;
            endcase
        end
    end

    // Data slots load only when written; flush optionally scrubs them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                OCC_EMPTY: if (accept) main_data <= in_data;
                OCC_BUSY: begin
                    if (accept && drain) main_data <= in_data;
                    else if (accept)     skid_data <= in_data;
                end
                OCC_FULL:  if (drain) main_data <= skid_data;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomised
// stream driven into an 8-bit and a 64-bit instance in lockstep.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        ir8, ov8, ir64, ov64;
    logic [7:0]  od8;
    logic [63:0] od64;
    logic [1:0]  occ8, occ64;

    logic [7:0]  q8[$];
    logic [63:0] q64[$];

    int checks   = 0;
    int failures = 0;

    pipe_skid_reg #(.DATA_W(8), .CLEAR_ON_FLUSH(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir8), .in_data(in_data[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
        .occupancy(occ8)
    );

    pipe_skid_reg #(.DATA_W(64), .CLEAR_ON_FLUSH(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir64), .in_data(in_data),
        .out_valid(ov64), .out_ready(out_ready), .out_data(od64),
        .occupancy(occ64)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // driver: apply inputs for the next edge, then return just after it
    task automatic drive(input bit v, input logic [63:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // scoreboards, evaluated mid-cycle when all signals are settled
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            check("rst_occ8", 64'(occ8), 64'd0);
            check("rst_ovalid8", 64'(ov8), 64'd0);
            check("rst_iready8", 64'(ir8), 64'd1);
        end else begin
            check("occ8", 64'(occ8), 64'(q8.size()));
            check("ovalid8", 64'(ov8), 64'(q8.size() != 0));
            check("iready8", 64'(ir8), 64'(q8.size() < 2));
            if (q8.size() != 0) check("odata8", 64'(od8), 64'(q8[0]));
            if (ov8 && out_ready && q8.size() != 0) void'(q8.pop_front());
            if (flush) q8.delete();
            else if (in_valid && ir8) q8.push_back(in_data[7:0]);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q64.delete();
            check("rst_occ64", 64'(occ64), 64'd0);
            check("rst_ovalid64", 64'(ov64), 64'd0);
        end else begin
            check("occ64", 64'(occ64), 64'(q64.size()));
            check("ovalid64", 64'(ov64), 64'(q64.size() != 0));
            check("iready64", 64'(ir64), 64'(q64.size() < 2));
            if (q64.size() != 0) check("odata64", od64, q64[0]);
            if (ov64 && out_ready && q64.size() != 0) void'(q64.pop_front());
            if (flush) q64.delete();
            else if (in_valid && ir64) q64.push_back(in_data);
        end
    end

    initial begin
        logic [7:0] stream [3];
        int sent;
        int cyc;
        bit acc;

        stream = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ovalid", 64'(ov8), 64'd0);
        check("reset_iready", 64'(ir8), 64'd1);
        check("reset_occ", 64'(occ8), 64'd0);
        check("reset_odata8", 64'(od8), 64'd0);
        check("reset_odata64", od64, 64'd0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);

        // streaming at full rate
        foreach (stream[i]) begin
            drive(1, 64'(stream[i]), 1, 0);
            check("stream_data", 64'(od8), 64'(stream[i]));
            check("stream_occ", 64'(occ8), 64'd1);
            check("stream_iready", 64'(ir8), 64'd1);
        end
        drive(0, 0, 1, 0);
        check("stream_empty", 64'(occ8), 64'd0);

        // fill the skid, hold under back-pressure, then drain
        drive(1, 64'hA0, 0, 0);
        drive(1, 64'hA1, 0, 0);
        check("full_occ", 64'(occ8), 64'd2);
        check("full_iready", 64'(ir8), 64'd0);
        check("full_data", 64'(od8), 64'hA0);
        repeat (5) begin
            drive(0, 0, 0, 0);
            check("hold_data", 64'(od8), 64'hA0);
            check("hold_valid", 64'(ov8), 64'd1);
            check("hold_iready", 64'(ir8), 64'd0);
        end
        drive(0, 0, 1, 0);
        check("drain1_data", 64'(od8), 64'hA1);
        check("drain1_iready", 64'(ir8), 64'd1);
        check("drain1_occ", 64'(occ8), 64'd1);
        drive(0, 0, 1, 0);
        check("drain2_occ", 64'(occ8), 64'd0);
        check("drain2_iready", 64'(ir8), 64'd1);

        // flush from FULL with a concurrent offer
        drive(1, 64'hB0, 0, 0);
        drive(1, 64'hB1, 0, 0);
        drive(1, 64'hB2, 0, 1);
        check("flush_valid", 64'(ov8), 64'd0);
        check("flush_occ", 64'(occ8), 64'd0);
        check("flush_iready", 64'(ir8), 64'd1);
        check("flush_data8", 64'(od8), 64'd0);
        check("flush_data64", od64, 64'd0);
        repeat (3) begin
            drive(0, 0, 1, 0);
            check("flush_no_b2", 64'(ov8), 64'd0);
        end

        // asynchronous reset between edges while FULL
        drive(1, 64'hD0, 0, 0);
        drive(1, 64'hD1, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(ov8), 64'd0);
        check("arst_iready", 64'(ir8), 64'd1);
        check("arst_occ", 64'(occ64), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 64'hC0, 1, 0);
        check("arst_c0", 64'(od8), 64'hC0);
        drive(0, 0, 1, 0);
        check("arst_c0_once", 64'(ov8), 64'd0);

        // randomised valid/ready; producer holds data while stalled
        sent = 0;
        cyc = 0;
        acc = 1'b0;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = 1'b0;
            acc = in_valid && ir8;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        check("rand_transfers", 64'(sent), 64'd1000);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        check("rand_q8_empty", 64'(q8.size()), 64'd0);
        check("rand_q64_empty", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
